am_similarity_accumulator: RTL and testbench



---
 rtl/am_similarity_accumulator.sv | 159 +++++++++++++++
 tb/tb_am_similarity_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_similarity_accumulator.sv
// am_similarity_accumulator
// Popcounts the per-class AND segments of a query, accumulates one score per
// class over SEQ_CYCLE_COUNT in-order segments, then scans the scores one class
// per cycle and presents the arg-max class and its score via valid/ready.
// Ports:
//   clk, rst                         clock, async active-high reset
//   comparing_query_hv_with_class_hv segment on and_array_in is valid
//   query_ctr                        segment index of and_array_in
//   and_array_in[c]                  AND of query segment with class c segment
//   busy                             not idle
//   seq_error                        one-cycle pulse on out-of-order segment
//   pred_valid / pred_ready          result handshake
//   predicted_class / best_score     winning class index and its total popcount
module am_similarity_accumulator #(
  parameter int unsigned DIMS_PER_CC     = 100,
  parameter int unsigned SEQ_CYCLE_COUNT = 10,
  parameter int unsigned NUM_CLASSES     = 26,
  localparam int unsigned CNT_W = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   comparing_query_hv_with_class_hv,
  input  logic [3:0]             query_ctr,
  input  logic [DIMS_PER_CC-1:0] and_array_in [0:NUM_CLASSES-1],
  output logic                   busy,
  output logic                   seq_error,
  output logic                   pred_valid,
  input  logic                   pred_ready,
  output logic [4:0]             predicted_class,
  output logic [CNT_W-1:0]       best_score
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] ARGMAX = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_q [0:NUM_CLASSES-1];
  logic [CNT_W-1:0] acc_d [0:NUM_CLASSES-1];
  logic [CNT_W-1:0] pc    [0:NUM_CLASSES-1];
  logic [4:0]       seg_cnt_q, seg_cnt_d;
  logic [4:0]       scan_idx_q, scan_idx_d;
  logic [4:0]       class_d;
  logic [CNT_W-1:0] score_d;
  logic             seq_error_d;
  logic             accept;

  // Per-class popcount of the current segment
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      pc[i] = CNT_W'($countones(and_array_in[i]));
    end
  end

  assign accept = comparing_query_hv_with_class_hv;

  // Next-state, accumulator and result logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    seg_cnt_d   = seg_cnt_q;
    scan_idx_d  = scan_idx_q;
    class_d     = predicted_class;
    score_d     = best_score;
    seq_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (query_ctr == 4'd0) begin
            for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = pc[i];
            seg_cnt_d = 5'd1;
            if (SEQ_CYCLE_COUNT == 1) begin
              state_d    = ARGMAX;
              scan_idx_d = 5'd0;
              class_d    = 5'd0;
              score_d    = '0;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            seq_error_d = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if ({1'b0, query_ctr} == seg_cnt_q) begin
            for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = acc_q[i] + pc[i];
            seg_cnt_d = seg_cnt_q + 5'd1;
            if (query_ctr == 4'(SEQ_CYCLE_COUNT - 1)) begin
              state_d    = ARGMAX;
              scan_idx_d = 5'd0;
              class_d    = 5'd0;
              score_d    = '0;
            end
          end else begin
            // Out-of-order segment aborts the whole query
            seq_error_d = 1'b1;
            for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = '0;
            seg_cnt_d = 5'd0;
            state_d   = IDLE;
          end
        end
      end

      ARGMAX: begin
        // Strict compare keeps the lowest index on ties
        if ((acc_q[scan_idx_q] > best_score) || (scan_idx_q == 5'd0)) begin
          score_d = acc_q[scan_idx_q];
          class_d = scan_idx_q;
        end
        if (scan_idx_q == 5'(NUM_CLASSES - 1)) begin
          state_d = DONE;
        end else begin
          scan_idx_d = scan_idx_q + 5'd1;
        end
      end

      DONE: begin
        if (pred_ready) begin
          state_d = IDLE;
          for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = '0;
          seg_cnt_d = 5'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= '0;
      seg_cnt_q       <= 5'd0;
      scan_idx_q      <= 5'd0;
      predicted_class <= 5'd0;
      best_score      <= '0;
      seq_error       <= 1'b0;
      busy            <= 1'b0;
      pred_valid      <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      seg_cnt_q       <= seg_cnt_d;
      scan_idx_q      <= scan_idx_d;
      predicted_class <= class_d;
      best_score      <= score_d;
      seq_error       <= seq_error_d;
      busy            <= (state_d != IDLE);
      pred_valid      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_am_similarity_accumulator.sv
// Self-checking bench for am_similarity_accumulator: directed scenarios plus
// random queries checked against a per-class sum / arg-max reference model.
module tb_am_similarity_accumulator;

  localparam int unsigned D  = 100;
  localparam int unsigned S  = 10;
  localparam int unsigned NC = 26;
  localparam int unsigned CW = $clog2(D * S + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          qual;
  logic [3:0]    query_ctr;
  logic [D-1:0]  and_array_in [0:NC-1];
  logic          busy, seq_error, pred_valid, pred_ready;
  logic [4:0]    predicted_class;
  logic [CW-1:0] best_score;

  am_similarity_accumulator dut (
    .clk                              (clk),
    .rst                              (rst),
    .comparing_query_hv_with_class_hv (qual),
    .query_ctr                        (query_ctr),
    .and_array_in                     (and_array_in),
    .busy                             (busy),
    .seq_error                        (seq_error),
    .pred_valid                       (pred_valid),
    .pred_ready                       (pred_ready),
    .predicted_class                  (predicted_class),
    .best_score                       (best_score)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [D-1:0] qd [0:S-1][0:NC-1];
  logic [31:0]  exp_class, exp_score;
  logic [4:0]   saved_class;
  int           lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [D-1:0] ones_vec(input int n);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [D-1:0] rand_vec();
    return D'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic fill_ones(input int win, input int n_win, input int n_other);
    for (int s = 0; s < S; s++)
      for (int c = 0; c < NC; c++)
        qd[s][c] = ones_vec((c == win) ? n_win : n_other);
  endtask

  task automatic fill_rand();
    for (int s = 0; s < S; s++)
      for (int c = 0; c < NC; c++)
        qd[s][c] = rand_vec();
  endtask

  task automatic drive_garbage();
    for (int c = 0; c < NC; c++) and_array_in[c] = rand_vec();
  endtask

  // Reference: total ones per class, first maximum wins
  task automatic model();
    int sums [NC];
    for (int c = 0; c < NC; c++) begin
      sums[c] = 0;
      for (int s = 0; s < S; s++) sums[c] += $countones(qd[s][c]);
    end
    exp_class = 0;
    exp_score = 32'(sums[0]);
    for (int c = 1; c < NC; c++)
      if (sums[c] > int'(exp_score)) begin
        exp_class = 32'(c);
        exp_score = 32'(sums[c]);
      end
  endtask

  // Full query: optional stall after stall_at segments, bp cycles of backpressure
  task automatic run_query(input int stall_at, input int stall_len, input int bp,
                           input int exp_lat, input string tag);
    int s, stalls, l;
    s = 0; stalls = 0; l = 0;
    model();
    while (s < int'(S)) begin
      if (s == stall_at && stalls < stall_len) begin
        qual = 1'b0;
        drive_garbage();
        stalls++;
      end else begin
        qual      = 1'b1;
        query_ctr = 4'(s);
        for (int c = 0; c < NC; c++) and_array_in[c] = qd[s][c];
        s++;
      end
      @(negedge clk);
      l++;
      if (l == 1) chk({tag, "_busy_start"}, 32'(busy), 1);
    end
    qual = 1'b0;
    while (!pred_valid && l < 300) begin
      @(negedge clk);
      l++;
    end
    chk({tag, "_latency"}, 32'(l), 32'(exp_lat));
    chk({tag, "_class"}, 32'(predicted_class), exp_class);
    chk({tag, "_score"}, 32'(best_score), exp_score);
    for (int k = 0; k < bp; k++) begin
      qual      = 1'($urandom);
      query_ctr = 4'($urandom);
      drive_garbage();
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(pred_valid), 1);
      chk({tag, "_bp_class"}, 32'(predicted_class), exp_class);
      chk({tag, "_bp_score"}, 32'(best_score), exp_score);
      chk({tag, "_bp_busy"}, 32'(busy), 1);
    end
    // Segment 0 offered on the handshake edge must not start a new query
    qual       = 1'b1;
    query_ctr  = 4'd0;
    pred_ready = 1'b1;
    @(negedge clk);
    qual       = 1'b0;
    pred_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(pred_valid), 0);
    chk({tag, "_hs_busy"}, 32'(busy), 0);
    chk({tag, "_hold_class"}, 32'(predicted_class), exp_class);
    chk({tag, "_hold_score"}, 32'(best_score), exp_score);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [4];
    int viol;
    seq = '{0, 1, 2, 4};
    rst = 1'b1; qual = 1'b0; query_ctr = 4'd0; pred_ready = 1'b0;
    for (int c = 0; c < NC; c++) and_array_in[c] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_error", 32'(seq_error), 0);
    chk("rst_valid", 32'(pred_valid), 0);
    chk("rst_class", 32'(predicted_class), 0);
    chk("rst_score", 32'(best_score), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single winner
    fill_ones(7, 100, 0);
    run_query(-1, 0, 0, 36, "win7");
    chk("win7_class_const", 32'(predicted_class), 7);
    chk("win7_score_const", 32'(best_score), 1000);

    // Tie resolves to lowest index
    for (int s = 0; s < S; s++)
      for (int c = 0; c < NC; c++)
        qd[s][c] = ones_vec((c == 3 || c == 12) ? 50 : 10);
    run_query(-1, 0, 0, 36, "tie");
    chk("tie_class_const", 32'(predicted_class), 3);
    chk("tie_score_const", 32'(best_score), 500);

    // All zero
    fill_ones(0, 0, 0);
    run_query(-1, 0, 0, 36, "zero");
    chk("zero_class_const", 32'(predicted_class), 0);

    // Random queries
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_query(-1, 0, 0, 36, "rand");
    end

    // Same data with a 5-cycle stall between segments 4 and 5
    saved_class = predicted_class;
    run_query(5, 5, 0, 41, "stall");
    chk("stall_same_class", 32'(predicted_class), 32'(saved_class));

    // Non-zero index while idle
    qual = 1'b1; query_ctr = 4'd3;
    @(negedge clk);
    qual = 1'b0;
    chk("idle_err_pulse", 32'(seq_error), 1);
    chk("idle_err_busy", 32'(busy), 0);
    @(negedge clk);
    chk("idle_err_clear", 32'(seq_error), 0);

    // Out-of-order mid-query abort
    fill_rand();
    for (int k = 0; k < 4; k++) begin
      qual = 1'b1;
      query_ctr = 4'(seq[k]);
      for (int c = 0; c < NC; c++) and_array_in[c] = qd[k][c];
      @(negedge clk);
      if (k == 2) chk("seq_no_err_yet", 32'(seq_error), 0);
    end
    qual = 1'b0;
    chk("seq_err_pulse", 32'(seq_error), 1);
    chk("seq_err_idle", 32'(busy), 0);
    @(negedge clk);
    chk("seq_err_one_cycle", 32'(seq_error), 0);
    viol = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pred_valid || busy) viol++;
    end
    chk("seq_no_valid", 32'(viol), 0);

    // Clean query after abort: no residue
    fill_ones(20, 100, 5);
    run_query(-1, 0, 0, 36, "after_err");
    chk("after_err_class", 32'(predicted_class), 20);
    chk("after_err_score", 32'(best_score), 1000);

    // Backpressure in DONE with garbage on the inputs
    fill_rand();
    for (int s = 0; s < S; s++) qd[s][4] = ones_vec(90);
    run_query(-1, 0, 10, 36, "bp");

    // Reset mid-accumulation
    fill_rand();
    for (int s = 0; s < 5; s++) begin
      qual = 1'b1; query_ctr = 4'(s);
      for (int c = 0; c < NC; c++) and_array_in[c] = qd[s][c];
      @(negedge clk);
    end
    qual = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(pred_valid), 0);
    chk("mid_rst_class", 32'(predicted_class), 0);
    chk("mid_rst_score", 32'(best_score), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_rand();
    for (int s = 0; s < S; s++) qd[s][25] = ones_vec(100);
    run_query(-1, 0, 0, 36, "after_rst");
    chk("after_rst_class", 32'(predicted_class), 25);
    chk("after_rst_score", 32'(best_score), 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
